// File: rtl/pc_pkg.sv
// Shared encodings for the next-PC unit: redirect modes and sequencer states.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JREG   = 2'd3
  } next_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational target calculation from the current PC: sequential, branch,
// jump and register targets plus the register-jump misalignment flag.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int IMM_WIDTH    = 16,
  parameter int JIDX_WIDTH   = 26,
  parameter int OFFSET_SHIFT = 2,
  parameter int INSTR_BYTES  = 4
) (
  input  logic [WIDTH-1:0]      i_pc,
  input  next_sel_e             i_sel,
  input  logic                  i_branch_taken,
  input  logic [IMM_WIDTH-1:0]  i_imm,
  input  logic [JIDX_WIDTH-1:0] i_jump_idx,
  input  logic [WIDTH-1:0]      i_reg_target,
  output logic [WIDTH-1:0]      o_pc_plus,
  output logic [WIDTH-1:0]      o_branch_target,
  output logic [WIDTH-1:0]      o_target,
  output logic                  o_misalign
);

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] HIGH_MASK = ALL_ONES << (JIDX_WIDTH + OFFSET_SHIFT);
  localparam logic [WIDTH-1:0] LOW_MASK  = ~(ALL_ONES << OFFSET_SHIFT);

  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_jump_target;
  logic [WIDTH-1:0] w_jreg_target;

  assign w_imm_ext       = {{(WIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
  assign o_pc_plus       = i_pc + WIDTH'(INSTR_BYTES);
  assign o_branch_target = o_pc_plus + (w_imm_ext << OFFSET_SHIFT);
  // Jump keeps the region bits of PC+INSTR_BYTES above the shifted index.
  assign w_jump_target   = (o_pc_plus & HIGH_MASK) | (WIDTH'(i_jump_idx) << OFFSET_SHIFT);
  assign w_jreg_target   = i_reg_target & ~LOW_MASK;

  // Target mux and misalignment detection for the requested mode.
  always_comb begin
    o_target   = o_pc_plus;
    o_misalign = 1'b0;
    case (i_sel)
      SEL_SEQ:    o_target = o_pc_plus;
      SEL_BRANCH: o_target = i_branch_taken ? o_branch_target : o_pc_plus;
      SEL_JUMP:   o_target = w_jump_target;
      SEL_JREG: begin
        o_target   = w_jreg_target;
        o_misalign = |(i_reg_target & LOW_MASK);
      end
      default: begin
        o_target   = o_pc_plus;
        o_misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter owner: PC register, one-entry redirect buffer held across
// stalls, sticky misalignment flag and a wrapping update counter.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              WIDTH        = 32,
  parameter int              IMM_WIDTH    = 16,
  parameter int              JIDX_WIDTH   = 26,
  parameter int              OFFSET_SHIFT = 2,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int              CNT_WIDTH    = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Stall,
  input  logic                  RedirValid,
  input  logic [1:0]            NextSel,
  input  logic                  BranchTaken,
  input  logic [IMM_WIDTH-1:0]  Imm,
  input  logic [JIDX_WIDTH-1:0] JumpIdx,
  input  logic [WIDTH-1:0]      RegTarget,
  input  logic                  ClearFault,
  output logic [WIDTH-1:0]      PC,
  output logic [WIDTH-1:0]      PCPlus,
  output logic [WIDTH-1:0]      BranchTarget,
  output logic                  PendingRedir,
  output logic                  Misaligned,
  output logic [CNT_WIDTH-1:0]  UpdateCount
);

  pc_state_e            r_state;
  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_buf;
  logic                 r_pend;
  logic                 r_mis;
  logic [CNT_WIDTH-1:0] r_cnt;

  pc_state_e            w_state_d;
  logic [WIDTH-1:0]     w_pc_d;
  logic [WIDTH-1:0]     w_buf_d;
  logic                 w_pend_d;
  logic                 w_mis_d;
  logic [CNT_WIDTH-1:0] w_cnt_d;
  logic [WIDTH-1:0]     w_target;
  logic                 w_misalign;

  pc_target_calc #(
    .WIDTH        (WIDTH),
    .IMM_WIDTH    (IMM_WIDTH),
    .JIDX_WIDTH   (JIDX_WIDTH),
    .OFFSET_SHIFT (OFFSET_SHIFT),
    .INSTR_BYTES  (INSTR_BYTES)
  ) u_target_calc (
    .i_pc            (r_pc),
    .i_sel           (next_sel_e'(NextSel)),
    .i_branch_taken  (BranchTaken),
    .i_imm           (Imm),
    .i_jump_idx      (JumpIdx),
    .i_reg_target    (RegTarget),
    .o_pc_plus       (PCPlus),
    .o_branch_target (BranchTarget),
    .o_target        (w_target),
    .o_misalign      (w_misalign)
  );

  // Next-state logic; targets are captured from the current PC and never recomputed.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_buf_d   = r_buf;
    w_pend_d  = r_pend;
    w_cnt_d   = r_cnt;
    case (r_state)
      RUN: begin
        if (!Stall) begin
          w_pc_d  = RedirValid ? w_target : PCPlus;
          w_cnt_d = r_cnt + CNT_WIDTH'(1);
        end else if (RedirValid) begin
          w_buf_d   = w_target;
          w_pend_d  = 1'b1;
          w_state_d = HOLD;
        end else begin
          w_state_d = RUN;
        end
      end
      HOLD: begin
        if (Stall) begin
          w_buf_d = RedirValid ? w_target : r_buf;
        end else begin
          w_pc_d    = RedirValid ? w_target : r_buf;
          w_pend_d  = 1'b0;
          w_cnt_d   = r_cnt + CNT_WIDTH'(1);
          w_state_d = RUN;
        end
      end
      default: begin
        w_state_d = RUN;
        w_pend_d  = 1'b0;
      end
    endcase
    // Every accepted request captures its target somewhere, so set wins over clear.
    if (RedirValid && w_misalign) begin
      w_mis_d = 1'b1;
    end else if (ClearFault) begin
      w_mis_d = 1'b0;
    end else begin
      w_mis_d = r_mis;
    end
  end

  // State registers with asynchronous reset that also discards any buffered redirect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
      r_pend  <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_buf   <= w_buf_d;
      r_pend  <= w_pend_d;
      r_mis   <= w_mis_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign PC           = r_pc;
  assign PendingRedir = r_pend;
  assign Misaligned   = r_mis;
  assign UpdateCount  = r_cnt;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with hand-computed expected PCs and flags;
// a second instance with a 3-bit counter exercises counter wrap.
module tb_pc_next_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall;
  logic        RedirValid;
  logic [1:0]  NextSel;
  logic        BranchTaken;
  logic [15:0] Imm;
  logic [25:0] JumpIdx;
  logic [31:0] RegTarget;
  logic        ClearFault;

  logic [31:0] PC, PCPlus, BranchTarget, UpdateCount;
  logic        PendingRedir, Misaligned;
  logic [31:0] PC2, PCPlus2, BranchTarget2;
  logic        PendingRedir2, Misaligned2;
  logic [2:0]  UpdateCount2;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pc_next_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .RedirValid(RedirValid),
    .NextSel(NextSel), .BranchTaken(BranchTaken), .Imm(Imm), .JumpIdx(JumpIdx),
    .RegTarget(RegTarget), .ClearFault(ClearFault), .PC(PC), .PCPlus(PCPlus),
    .BranchTarget(BranchTarget), .PendingRedir(PendingRedir),
    .Misaligned(Misaligned), .UpdateCount(UpdateCount)
  );

  pc_next_unit #(.CNT_WIDTH(3)) dut_cnt3 (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .RedirValid(RedirValid),
    .NextSel(NextSel), .BranchTaken(BranchTaken), .Imm(Imm), .JumpIdx(JumpIdx),
    .RegTarget(RegTarget), .ClearFault(ClearFault), .PC(PC2), .PCPlus(PCPlus2),
    .BranchTarget(BranchTarget2), .PendingRedir(PendingRedir2),
    .Misaligned(Misaligned2), .UpdateCount(UpdateCount2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic stall, input logic valid, input logic [1:0] sel,
                       input logic taken, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic [31:0] regt);
    Stall       = stall;
    RedirValid  = valid;
    NextSel     = sel;
    BranchTaken = taken;
    Imm         = imm;
    JumpIdx     = jidx;
    RegTarget   = regt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic jreg(input logic stall, input logic [31:0] t);
    drive(stall, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, t);
  endtask

  initial begin
    Reset_n    = 1'b0;
    ClearFault = 1'b0;
    idle();
    #12;
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_cnt", UpdateCount, 32'h0);
    check_eq("rst_pend", {31'h0, PendingRedir}, 32'h0);
    check_eq("rst_mis", {31'h0, Misaligned}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(); check_eq("seq_pc1", PC, 32'h4);
    step(); check_eq("seq_pc2", PC, 32'h8);
    step(); check_eq("seq_pc3", PC, 32'hC);
    check_eq("seq_cnt3", UpdateCount, 32'd3);

    // Branch with Imm = -1 instruction
    jreg(1'b0, 32'h100); step();
    check_eq("jreg_100", PC, 32'h100);
    drive(1'b0, 1'b1, 2'd1, 1'b1, 16'hFFFF, 26'h0, 32'h0); #1;
    check_eq("pcplus_100", PCPlus, 32'h104);
    check_eq("btarget_neg", BranchTarget, 32'h100);
    step(); check_eq("br_taken_neg", PC, 32'h100);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 16'hFFFF, 26'h0, 32'h0);
    step(); check_eq("br_not_taken", PC, 32'h104);
    drive(1'b0, 1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0);
    step(); check_eq("br_taken_pos", PC, 32'h148);

    // Address wrap
    jreg(1'b0, 32'hFFFF_FFFC); step();
    check_eq("jreg_top", PC, 32'hFFFF_FFFC);
    idle(); #1;
    check_eq("pcplus_wrap", PCPlus, 32'h0);
    step(); check_eq("seq_wrap", PC, 32'h0);

    // Jump keeps region bits of PC+4
    jreg(1'b0, 32'hF000_0000); step();
    drive(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, 26'h1, 32'h0);
    step(); check_eq("jump_region", PC, 32'hF000_0004);

    // Stalled redirects overwrite the buffer
    jreg(1'b0, 32'h1000); step();
    check_eq("cnt_pre_stall", UpdateCount, 32'd12);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 16'h0, 26'h40, 32'h0);
    step();
    check_eq("stall_pend", {31'h0, PendingRedir}, 32'h1);
    check_eq("stall_pc_hold", PC, 32'h1000);
    check_eq("stall_cnt_hold", UpdateCount, 32'd12);
    jreg(1'b1, 32'h2000); step();
    check_eq("hold_pc_hold", PC, 32'h1000);
    idle(); step();
    check_eq("release_pc", PC, 32'h2000);
    check_eq("release_pend", {31'h0, PendingRedir}, 32'h0);
    check_eq("release_cnt", UpdateCount, 32'd13);

    // Live request wins over buffered one
    jreg(1'b1, 32'h500); step();
    jreg(1'b0, 32'h600); step();
    check_eq("live_wins", PC, 32'h600);
    check_eq("live_pend", {31'h0, PendingRedir}, 32'h0);

    // Misalignment flag
    jreg(1'b0, 32'h3006); step();
    check_eq("misal_pc", PC, 32'h3004);
    check_eq("misal_set", {31'h0, Misaligned}, 32'h1);
    idle(); step();
    check_eq("misal_sticky", {31'h0, Misaligned}, 32'h1);
    ClearFault = 1'b1; step(); ClearFault = 1'b0;
    check_eq("misal_clear", {31'h0, Misaligned}, 32'h0);
    jreg(1'b0, 32'h3007); ClearFault = 1'b1; step(); ClearFault = 1'b0;
    check_eq("misal_set_wins", {31'h0, Misaligned}, 32'h1);
    idle(); ClearFault = 1'b1; step(); ClearFault = 1'b0;
    jreg(1'b1, 32'h4002); step();
    check_eq("misal_stall_set", {31'h0, Misaligned}, 32'h1);
    idle(); step();
    check_eq("misal_stall_pc", PC, 32'h4000);

    // Asynchronous reset while a redirect is buffered
    drive(1'b1, 1'b1, 2'd2, 1'b0, 16'h0, 26'h40, 32'h0);
    step();
    check_eq("pre_rst_pend", {31'h0, PendingRedir}, 32'h1);
    idle();
    #2 Reset_n = 1'b0;
    #1;
    check_eq("arst_pc", PC, 32'h0);
    check_eq("arst_pend", {31'h0, PendingRedir}, 32'h0);
    check_eq("arst_cnt", UpdateCount, 32'h0);
    check_eq("arst_mis", {31'h0, Misaligned}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    check_eq("post_rst_pc", PC, 32'h4);

    // Counter wrap on the 3-bit instance
    for (int i = 0; i < 6; i++) step();
    check_eq("cnt3_max", {29'h0, UpdateCount2}, 32'd7);
    step();
    check_eq("cnt3_wrap", {29'h0, UpdateCount2}, 32'd0);
    check_eq("cnt32_eight", UpdateCount, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Owns the program counter register and computes the next PC for the fetch stage.
- Generalises the combinational branch-target adder to parametrised widths, immediate sizes and shift amounts.
- Adds four next-PC modes, stall handling, a one-entry pending-redirect buffer, alignment checking and an update counter.
- Sits between fetch (consumes PC) and decode/execute (drives redirects).

Parameters:
- WIDTH, 32, PC and address width in bits.
- IMM_WIDTH, 16, branch immediate width (signed).
- JIDX_WIDTH, 26, jump index width.
- OFFSET_SHIFT, 2, left shift applied to the immediate and the jump index.
- INSTR_BYTES, 4, sequential PC increment.
- RESET_PC, 0, PC value after reset.
- CNT_WIDTH, 32, width of the update counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Stall  in  1  holds PC when 1.
- RedirValid  in  1  a redirect request is present this cycle.
- NextSel  in  2  redirect mode: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG.
- BranchTaken  in  1  qualifies BRANCH mode.
- Imm  in  IMM_WIDTH  signed branch offset, in instructions.
- JumpIdx  in  JIDX_WIDTH  jump index.
- RegTarget  in  WIDTH  register jump target.
- ClearFault  in  1  clears Misaligned.
- PC  out  WIDTH  current PC.
- PCPlus  out  WIDTH  PC+INSTR_BYTES, combinational.
- BranchTarget  out  WIDTH  PCPlus + (sext(Imm)<<OFFSET_SHIFT), combinational.
- PendingRedir  out  1  a redirect is buffered.
- Misaligned  out  1  sticky JREG misalignment flag.
- UpdateCount  out  CNT_WIDTH  number of PC updates since reset.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - PC=RESET_PC, PendingRedir=0, Misaligned=0, UpdateCount=0, FSM=RUN.
  - A reset asserted mid-stall discards the buffered redirect.
- Arithmetic:
  - All sums are modulo 2^WIDTH; carry out is discarded.
  - Imm is sign-extended to WIDTH before the shift.
- Target per mode:
  - SEQ: PCPlus.
  - BRANCH: BranchTarget if BranchTaken, else PCPlus.
  - JUMP: {PCPlus[WIDTH-1:JIDX_WIDTH+OFFSET_SHIFT], JumpIdx, OFFSET_SHIFT zeros}.
  - JREG: RegTarget with low OFFSET_SHIFT bits forced to 0.
  - JREG with RegTarget low bits nonzero sets Misaligned=1 on the same edge the target is captured.
- Targets are computed from the current PC at request time and stored; they are never recomputed later.
- FSM states: RUN, HOLD.
- RUN, Stall=0:
  - Next PC is the redirect target if RedirValid=1, else PCPlus.
  - UpdateCount increments.
  - Latency: the new PC is visible the cycle after the request.
- RUN, Stall=1:
  - PC and UpdateCount hold.
  - If RedirValid=1, the target is stored in the buffer, PendingRedir=1, and the FSM goes to HOLD.
  - If RedirValid=0, the FSM stays in RUN.
- HOLD, Stall=1:
  - PC holds.
  - A new RedirValid overwrites the buffer (latest wins; the target is computed from the held PC).
- HOLD, Stall=0:
  - If RedirValid=1, the live request wins over the buffer.
  - Otherwise PC takes the buffered target.
  - PendingRedir=0, UpdateCount increments, FSM goes to RUN.
- Misaligned:
  - Stays set until ClearFault=1.
  - ClearFault and a new misalignment on the same edge leave Misaligned=1 (set wins).
- UpdateCount wraps from all-ones to 0.
- No combinational path from any input to PC.

Decomposition:
- Shared package pc_pkg holds:
  - the NextSel encodings SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG;
  - the FSM state encodings RUN, HOLD.
- One natural sub-module: pc_target_calc, a purely combinational block.
  - Inputs: PC, NextSel, BranchTaken, Imm, JumpIdx, RegTarget.
  - Outputs: PCPlus, BranchTarget, selected target, misalign flag.
- Top level holds the PC register, the redirect buffer, the FSM, the fault flag and the counter.

Test Plan:
- Reset: release Reset_n with RESET_PC=0, no redirects, 3 cycles -> PC 0x0, 0x4, 0x8, 0xC; UpdateCount=3.
- Branch negative:
  - PC=0x100, BRANCH, BranchTaken=1, Imm=0xFFFF -> next PC=0x100.
  - Same request with BranchTaken=0 -> next PC=0x104.
- Wrap:
  - PC=0xFFFFFFFC, SEQ -> next PC=0x0.
  - UpdateCount preloaded near all-ones, incremented -> wraps to 0.
- Stall redirect:
  - Stall=1, JUMP with JumpIdx=0x40 at PC=0x1000 -> PendingRedir=1, PC holds.
  - Second request JREG to 0x2000 while stalled -> buffer overwritten.
  - Release stall -> PC=0x2000, PendingRedir=0.
- Misaligned: JREG with RegTarget=0x3006 -> PC=0x3004, Misaligned=1; ClearFault pulse -> Misaligned=0.
- Reset mid-HOLD: assert Reset_n=0 asynchronously while PendingRedir=1 -> all outputs return to reset values immediately; no redirect is applied after release.
